cpu_ctrl_fsm: RTL

Multi-cycle fetch/decode/execute sequencer for the accumulator CPU datapath (PC, IR, ACC, MDR, MAR, zflag registers).
- Generates every load enable, mux select and ALU op for the register bank and datapath muxes.
- Runs the memory request/acknowledge handshake.
- Owns no architectural state; only FSM state (plus optional timeout counter).

---
 rtl/cpu_ctrl_pkg.sv | 28 ++
 rtl/cpu_ctrl_decode.sv | 44 ++++
 rtl/cpu_ctrl_fsm.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, ALU-op and state definitions for the accumulator CPU control sequencer.
package cpu_ctrl_pkg;

  localparam int unsigned OpcWDefault = 4;

  localparam logic [3:0] OpLoad  = 4'h0;
  localparam logic [3:0] OpStore = 4'h1;
  localparam logic [3:0] OpAdd   = 4'h2;
  localparam logic [3:0] OpSub   = 4'h3;
  localparam logic [3:0] OpJmp   = 4'h4;
  localparam logic [3:0] OpJz    = 4'h5;
  localparam logic [3:0] OpHalt  = 4'hF;

  localparam logic [1:0] AluPass = 2'b00;
  localparam logic [1:0] AluAdd  = 2'b01;
  localparam logic [1:0] AluSub  = 2'b10;

  typedef enum logic [2:0] {
    StFetch0 = 3'd0,
    StFetch1 = 3'd1,
    StFetch2 = 3'd2,
    StDecode = 3'd3,
    StMem    = 3'd4,
    StExec   = 3'd5,
    StHalt   = 3'd6
  } state_e;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode classifier feeding the control sequencer.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = OpcWDefault
) (
  input  logic [OPC_W-1:0] opcode,
  output logic             needs_mem,
  output logic             is_store,
  output logic             is_jmp,
  output logic             is_jz,
  output logic             is_halt,
  output logic [1:0]       alu_op
);

  always_comb begin
    needs_mem = 1'b0;
    is_store  = 1'b0;
    is_jmp    = 1'b0;
    is_jz     = 1'b0;
    is_halt   = 1'b0;
    alu_op    = AluPass;
    case (opcode)
      OPC_W'(OpLoad):  needs_mem = 1'b1;
      OPC_W'(OpStore): begin
        needs_mem = 1'b1;
        is_store  = 1'b1;
      end
      OPC_W'(OpAdd): begin
        needs_mem = 1'b1;
        alu_op    = AluAdd;
      end
      OPC_W'(OpSub): begin
        needs_mem = 1'b1;
        alu_op    = AluSub;
      end
      OPC_W'(OpJmp):  is_jmp  = 1'b1;
      OPC_W'(OpJz):   is_jz   = 1'b1;
      OPC_W'(OpHalt): is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Fetch/decode/execute sequencer for the accumulator CPU datapath.
// Optional memory-wait timeout enabled by defining CPU_CTRL_MEM_TIMEOUT_EN.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W          = OpcWDefault,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] ir_opcode,
  input  logic             zflag,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mar_ld,
  output logic             mar_sel,
  output logic             mdr_ld,
  output logic             ir_ld,
  output logic             pc_inc,
  output logic             pc_ld,
  output logic             acc_ld,
  output logic             zflag_ld,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             mem_err,
  output logic [2:0]       state_dbg
);

  state_e     state_q, state_d;
  logic       dec_needs_mem, dec_is_store, dec_is_jmp, dec_is_jz, dec_is_halt;
  logic [1:0] dec_alu_op;
  logic       timeout;

  cpu_ctrl_decode #(
    .OPC_W(OPC_W)
  ) u_decode (
    .opcode   (ir_opcode),
    .needs_mem(dec_needs_mem),
    .is_store (dec_is_store),
    .is_jmp   (dec_is_jmp),
    .is_jz    (dec_is_jz),
    .is_halt  (dec_is_halt),
    .alu_op   (dec_alu_op)
  );

`ifdef CPU_CTRL_MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_err_q, mem_err_d;
  logic            in_wait_state;

  assign in_wait_state = (state_q == StFetch1) || (state_q == StMem);
  // Fires on the wait cycle that brings the count up to the limit; an ack that cycle wins.
  assign timeout = in_wait_state && !mem_ack && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    if (!in_wait_state) begin
      cnt_d = '0;
    end else if (!mem_ack) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (timeout) begin
      mem_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q & ~rst;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mar_ld   = 1'b0;
    mar_sel  = 1'b0;
    mdr_ld   = 1'b0;
    ir_ld    = 1'b0;
    pc_inc   = 1'b0;
    pc_ld    = 1'b0;
    acc_ld   = 1'b0;
    zflag_ld = 1'b0;
    alu_op   = AluPass;
    halted   = 1'b0;

    unique case (state_q)
      StFetch0: begin
        mar_ld  = 1'b1;
        state_d = StFetch1;
      end
      StFetch1: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          mdr_ld  = 1'b1;
          pc_inc  = 1'b1;
          state_d = StFetch2;
        end
      end
      StFetch2: begin
        ir_ld   = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        state_d = StFetch0;
        if (dec_needs_mem) begin
          mar_ld  = 1'b1;
          mar_sel = 1'b1;
          state_d = StMem;
        end else if (dec_is_jmp) begin
          pc_ld = 1'b1;
        end else if (dec_is_jz) begin
          pc_ld = zflag;
        end else if (dec_is_halt) begin
          state_d = StHalt;
        end
      end
      StMem: begin
        mem_req = 1'b1;
        mem_we  = dec_is_store;
        if (mem_ack) begin
          if (dec_is_store) begin
            state_d = StFetch0;
          end else begin
            mdr_ld  = 1'b1;
            state_d = StExec;
          end
        end
      end
      StExec: begin
        acc_ld   = 1'b1;
        zflag_ld = 1'b1;
        alu_op   = dec_alu_op;
        state_d  = StFetch0;
      end
      StHalt: halted = 1'b1;
      default: state_d = StFetch0;
    endcase

    if (timeout) begin
      state_d = StHalt;
    end

    // Reset cycle presents a fully quiet control bus, whatever state was left behind.
    if (rst) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mar_ld   = 1'b0;
      mar_sel  = 1'b0;
      mdr_ld   = 1'b0;
      ir_ld    = 1'b0;
      pc_inc   = 1'b0;
      pc_ld    = 1'b0;
      acc_ld   = 1'b0;
      zflag_ld = 1'b0;
      alu_op   = AluPass;
      halted   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_dbg = rst ? 3'd0 : state_q;

endmodule
